// File: rtl/uart_pkg.sv
// Shared UART-path constants: byte width, rx FIFO depth and the overflow counter width.
package uart_pkg;
  localparam int UART_DATA_WIDTH       = 8;
  localparam int RX_FIFO_DEPTH_LOG2    = 4;
  localparam int RX_FIFO_OVF_CNT_WIDTH = 8;
endpackage

// File: rtl/fifo_ram.sv
// Register-array storage for the rx byte FIFO: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Elastic first-word-fall-through byte buffer between the UART receiver and the command interface.
// Define RX_FIFO_OVF_COUNT_EN to add the saturating dropped-byte counter o_ovf_count.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_overflow,
  input  logic                  i_clear_ovf
`ifdef RX_FIFO_OVF_COUNT_EN
  ,
  output logic [RX_FIFO_OVF_CNT_WIDTH-1:0] o_ovf_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE       = (DEPTH_LOG2+1)'(1);

  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count_q, count_next;
  logic                full_q, ovf_q;
  logic                push, pop, drop, empty;

  assign empty = (wr_ptr == rd_ptr);
  assign pop   = ~empty & i_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push  = i_rx_done & (~full_q | pop);
  assign drop  = i_rx_done & full_q & ~pop;

  always_comb begin
    count_next = count_q;
    if (push && !pop)      count_next = count_q + ONE;
    else if (pop && !push) count_next = count_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_CNT);
      if (drop)             ovf_q <= 1'b1;
      else if (i_clear_ovf) ovf_q <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[DEPTH_LOG2-1:0]),
    .wdata(i_rx_data),
    .raddr(rd_ptr[DEPTH_LOG2-1:0]),
    .rdata(o_data)
  );

  assign o_valid    = ~empty;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_overflow = ovf_q;

`ifdef RX_FIFO_OVF_COUNT_EN
  logic [RX_FIFO_OVF_CNT_WIDTH-1:0] ovf_cnt_q;

  // A clear coinciding with a drop restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset)                  ovf_cnt_q <= '0;
    else if (i_clear_ovf)       ovf_cnt_q <= {{(RX_FIFO_OVF_CNT_WIDTH-1){1'b0}}, drop};
    else if (drop && ovf_cnt_q != '1)
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end

  assign o_ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed self-checking bench for rx_byte_fifo: vector table plus multi-cycle corner sequences.
module tb_rx_byte_fifo;

  logic       clk;
  logic       reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_count;
  logic       o_full;
  logic       o_overflow;
  logic       i_clear_ovf;
`ifdef RX_FIFO_OVF_COUNT_EN
  logic [7:0] o_ovf_count;
`endif

  rx_byte_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx_done  (i_rx_done),
    .i_rx_data  (i_rx_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .i_clear_ovf(i_clear_ovf)
`ifdef RX_FIFO_OVF_COUNT_EN
    ,
    .o_ovf_count(o_ovf_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
  task automatic cyc(input logic rx, input logic [7:0] d, input logic rdy, input logic clr);
    i_rx_done   = rx;
    i_rx_data   = d;
    i_ready     = rdy;
    i_clear_ovf = clr;
    @(posedge clk);
    #1;
    i_rx_done   = 1'b0;
    i_rx_data   = 8'h00;
    i_ready     = 1'b0;
    i_clear_ovf = 1'b0;
  endtask

  typedef struct {
    logic       rx;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [7:0] q[$];
    int pushed, popped, cycles, sz;
    logic rx, rdy, p;
    logic [7:0] exp_b;

    // rx, d, rdy, clr | valid, data, count, full, ovf (state after the edge)
    vt[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0};
    vt[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 5'd3, 1'b0, 1'b0};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd2, 1'b0, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0};
    vt[8] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0};
    vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    reset = 1'b1;
    i_rx_done = 1'b0; i_rx_data = 8'h00; i_ready = 1'b0; i_clear_ovf = 1'b0;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    reset = 1'b0;

    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_overflow, 0);
`ifdef RX_FIFO_OVF_COUNT_EN
    chk("rst_ovfcnt", o_ovf_count, 0);
`endif

    // No combinational path from rx_done to valid.
    i_rx_done = 1'b1; i_rx_data = 8'h99;
    #1;
    chk("no_comb_valid", o_valid, 0);
    i_rx_done = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].rx, vt[i].d, vt[i].rdy, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), o_valid, vt[i].ev);
      if (vt[i].ev) chk($sformatf("vec%0d_data", i), o_data, vt[i].ed);
      chk($sformatf("vec%0d_count", i), o_count, vt[i].ec);
      chk($sformatf("vec%0d_full", i), o_full, vt[i].ef);
      chk($sformatf("vec%0d_ovf", i), o_overflow, vt[i].eo);
    end

    // Fill to the brim, then overflow.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 14) begin
        chk("fill15_count", o_count, 15);
        chk("fill15_full", o_full, 0);
      end
    end
    chk("fill16_count", o_count, 16);
    chk("fill16_full", o_full, 1);
    chk("fill16_head", o_data, 8'h00);
    chk("fill16_ovf", o_overflow, 0);

    cyc(1, 8'hAA, 0, 0);
    chk("drop_count", o_count, 16);
    chk("drop_full", o_full, 1);
    chk("drop_ovf", o_overflow, 1);
    chk("drop_head", o_data, 8'h00);
`ifdef RX_FIFO_OVF_COUNT_EN
    chk("drop_ovfcnt", o_ovf_count, 1);
`endif

    cyc(0, 8'h00, 0, 1);
    chk("clear_ovf", o_overflow, 0);
`ifdef RX_FIFO_OVF_COUNT_EN
    chk("clear_ovfcnt", o_ovf_count, 0);
`endif

    // Full with simultaneous push and pop.
    cyc(1, 8'h55, 1, 0);
    chk("fullpp_count", o_count, 16);
    chk("fullpp_full", o_full, 1);
    chk("fullpp_ovf", o_overflow, 0);
    chk("fullpp_head", o_data, 8'h01);

    // Clear and drop together: drop wins.
    cyc(1, 8'hBB, 0, 1);
    chk("clrdrop_ovf", o_overflow, 1);
    chk("clrdrop_count", o_count, 16);
`ifdef RX_FIFO_OVF_COUNT_EN
    chk("clrdrop_ovfcnt", o_ovf_count, 1);
`endif

    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 1) : 8'h55;
      chk($sformatf("drain%0d_valid", i), o_valid, 1);
      chk($sformatf("drain%0d_data", i), o_data, exp_b);
      cyc(0, 8'h00, 1, 0);
    end
    chk("drained_valid", o_valid, 0);
    chk("drained_count", o_count, 0);
    chk("drained_full", o_full, 0);
    cyc(0, 8'h00, 0, 1);

    // Pointer wrap with random consumer stalls, checked against a queue model.
    pushed = 0; popped = 0; cycles = 0;
    while ((pushed < 40 || popped < 40) && cycles < 2000) begin
      sz = q.size();
      chk("wrap_valid", o_valid, (sz != 0));
      chk("wrap_count", o_count, sz);
      chk("wrap_full", o_full, (sz == 16));
      if (sz != 0) chk("wrap_data", o_data, q[0]);
      rx  = (pushed < 40) && (sz < 16) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      p   = (sz != 0) && rdy;
      if (p) begin
        void'(q.pop_front());
        popped++;
      end
      if (rx) q.push_back(8'(pushed * 7 + 3));
      cyc(rx, 8'(pushed * 7 + 3), rdy, 0);
      if (rx) pushed++;
      cycles++;
    end
    chk("wrap_popped", popped, 40);
    chk("wrap_end_count", o_count, 0);

    // Reset mid-stream: 5 bytes held with overflow set.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1, 0);
    chk("pre_rst_count", o_count, 5);
    chk("pre_rst_ovf", o_overflow, 1);
    chk("pre_rst_head", o_data, 8'hCB);
    reset = 1'b1;
    cyc(1, 8'h12, 1, 0);
    reset = 1'b0;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_full", o_full, 0);
    chk("mid_rst_ovf", o_overflow, 0);
    cyc(1, 8'h77, 0, 0);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_head", o_data, 8'h77);
    chk("post_rst_count", o_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
- Elastic byte buffer between the UART receiver and the command interface.
- Captures every byte qualified by the UART rx-done pulse.
- Presents bytes in order on a valid/ready stream, so the interface may stall while the ALU result is transmitted without losing incoming operand or opcode bytes.
- Flags and counts overruns when the line outpaces the consumer.

Parameters:
- DATA_WIDTH, 8: width of one received byte.
- DEPTH_LOG2, 4: log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (16 by default).

Ports:
- clk, input, 1: single system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- i_rx_done, input, 1: one-cycle strobe from the UART receiver; the byte on i_rx_data is valid this cycle.
- i_rx_data, input, DATA_WIDTH: received byte.
- o_data, output, DATA_WIDTH: byte at FIFO head; meaningful only while o_valid=1.
- o_valid, output, 1: FIFO non-empty; a head byte is presented.
- i_ready, input, 1: consumer accepts o_data this cycle when o_valid=1 (pop).
- o_count, output, DEPTH_LOG2+1: current number of stored bytes, 0..DEPTH.
- o_full, output, 1: o_count == DEPTH.
- o_overflow, output, 1: sticky; set when a byte was dropped.
- i_clear_ovf, input, 1: clears o_overflow.

Behaviour:
- Reset: read and write pointers = 0, count = 0, o_valid=0, o_full=0, o_overflow=0. o_data is a don't-care while o_valid=0. Storage is not reset.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1). The low bits address storage. Empty means pointers are equal; full means the low bits are equal and the MSBs differ.
- Push = i_rx_done & (!o_full | pop). Pop = o_valid & i_ready.
- Write latency: a byte pushed in cycle N is stored at the rising edge ending N. o_valid=1 and o_data = that byte in N+1 if the FIFO was empty. There is no combinational path from i_rx_done to o_valid.
- Read: o_data is driven combinationally from storage[rd_ptr], so the output is first-word-fall-through. A pop in cycle N advances the read pointer, and the next byte (if any) appears in N+1.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same cycle.
  - When empty, no pop occurs (o_valid=0), so only the push happens.
- Pop while empty: ignored; pointers and count unchanged.
- Overflow:
  - Condition: i_rx_done while o_full and no pop.
  - The byte is dropped; storage, pointers and count are unchanged.
  - o_overflow=1 from the next cycle and stays set until i_clear_ovf.
  - If i_clear_ovf and a new overflow occur in the same cycle, the overflow wins and o_overflow stays 1.
- o_count and o_full are registered and updated on the same edge as the pointers.
- Reset asserted mid-stream: the next cycle shows the empty state. Any bytes held or in flight are discarded, and o_overflow is cleared.

Optional Feature:
- Macro: RX_FIFO_OVF_COUNT_EN.
- Defined:
  - Adds output o_ovf_count (8 bits): a saturating count of dropped bytes.
  - It increments with each drop, holds at 255, and resets to 0 on reset or i_clear_ovf.
  - A clear and a drop in the same cycle give 1.
- Undefined: the port and counter are absent; only the sticky o_overflow flag exists.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_WIDTH default (8), shared with the UART and the interface.
  - RX_FIFO_DEPTH_LOG2 default (4).
  - The ovf-count width constant (8).
- One natural sub-module, fifo_ram: a simple dual-port register array with a synchronous write port and a combinational asynchronous read port.
- Pointer, count and flag logic stays in rx_byte_fifo.

Test Plan:
- Basic order: push 0x11, 0x22, 0x33 on separate cycles with i_ready=0, then i_ready=1. Expected: o_valid goes high the cycle after the first push; o_data reads 0x11, 0x22, 0x33 on consecutive cycles; o_count goes 3→0; o_valid=0 afterward.
- Fill and overflow: push 16 bytes 0x00..0x0F, then 0xAA. Expected: o_full=1 after the 16th push; 0xAA is dropped; o_overflow=1 next cycle; o_count=16; drained data is 0x00..0x0F only.
- Full with simultaneous push and pop: FIFO full, i_rx_done with 0x55 and i_ready=1 in the same cycle. Expected: 0x00 popped, 0x55 accepted, o_count stays 16, o_overflow stays 0, and 0x55 exits last.
- Pointer wrap: push and pop 40 bytes with random i_ready. Expected: output order equals input order across several wraps, with no spurious full or empty.
- Clear vs overflow: with o_overflow=1, pulse i_clear_ovf. Expected: o_overflow=0 next cycle. Then, while full, assert i_clear_ovf in the same cycle as a dropped push. Expected: o_overflow stays 1 (with RX_FIFO_OVF_COUNT_EN, o_ovf_count=1).
- Reset mid-stream: 5 bytes stored, o_overflow=1; assert reset for one cycle. Expected: o_valid=0, o_count=0, o_full=0, o_overflow=0 next cycle; a push of 0x77 then appears as the head.
